// File: rtl/veri_bellek_hakemi.sv
// Two-port round-robin arbiter/sequencer for a single-port data memory.
// Each transaction runs IDLE -> ACCESS -> RESP with ack two cycles after grant.
module veri_bellek_hakemi #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                gnt_valid;
    logic                gnt_port;
    logic [31:0]         sel_addr;
    logic                sel_we;
    logic [DATA_W-1:0]   sel_wdata;
    logic                addr_bad;

    logic                grant_port_q;
    logic                last_grant_q;
    logic                we_q;
    logic                err_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;

    logic                resp_fire;
    logic [DATA_W-1:0]   resp_data;
    logic                upd0, upd1;

    always_comb begin
        state_nxt = state;
        gnt_valid = 1'b0;
        gnt_port  = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    gnt_valid = 1'b1;
                    gnt_port  = ~last_grant_q;
                end else if (m0_req) begin
                    gnt_valid = 1'b1;
                    gnt_port  = 1'b0;
                end else if (m1_req) begin
                    gnt_valid = 1'b1;
                    gnt_port  = 1'b1;
                end
                if (gnt_valid) state_nxt = ACCESS;
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_addr  = gnt_port ? m1_addr  : m0_addr;
        sel_we    = gnt_port ? m1_we    : m0_we;
        sel_wdata = gnt_port ? m1_wdata : m0_wdata;
        addr_bad  = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_W+2] != '0);
    end

    // Strobes are qualified with rst so a reset in ACCESS/RESP kills the
    // memory access and the ack in that same cycle.
    always_comb begin
        busy      = (state != IDLE);
        mem_en    = (state == ACCESS) && !err_q && !rst;
        mem_we    = we_q;
        mem_addr  = waddr_q;
        mem_wdata = wdata_q;
        resp_fire = (state == RESP) && !rst;
        m0_ack    = resp_fire && !grant_port_q;
        m1_ack    = resp_fire &&  grant_port_q;
        m0_err    = m0_ack && err_q;
        m1_err    = m1_ack && err_q;
        resp_data = err_q ? '0 : mem_rdata;
        upd0      = m0_ack && (!we_q || err_q);
        upd1      = m1_ack && (!we_q || err_q);
        m0_rdata  = upd0 ? resp_data : rdata0_q;
        m1_rdata  = upd1 ? resp_data : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant_port_q <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_valid) begin
                grant_port_q <= gnt_port;
                last_grant_q <= gnt_port;
                we_q         <= sel_we;
                err_q        <= addr_bad;
                waddr_q      <= sel_addr[ADDR_W+1:2];
                wdata_q      <= sel_wdata;
            end
            if (upd0) rdata0_q <= resp_data;
            if (upd1) rdata1_q <= resp_data;
        end
    end

endmodule
